// File: rtl/life_pkg.sv
// Shared definitions for the life grid engine.
// Holds the engine FSM state type, the neighbour-count width, the common
// rule presets (B3 / S23), the single-cell edit opcodes and a popcount helper
// used by the row rule logic.
// Build option: LIFE_TORUS_EN (consumed by life_grid_engine) selects a toroidal grid.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } life_state_e;

  localparam int NBR_W = 4;

  localparam logic [8:0] RULE_B3  = 9'h008;
  localparam logic [8:0] RULE_S23 = 9'h00C;

  localparam logic [1:0] EDIT_TOGGLE = 2'b00;
  localparam logic [1:0] EDIT_SET    = 2'b01;
  localparam logic [1:0] EDIT_CLEAR  = 2'b10;
  localparam logic [1:0] EDIT_NOP    = 2'b11;

  // Number of live cells among the eight neighbours (0..8).
  function automatic logic [NBR_W-1:0] count_nbrs(input logic [7:0] nbrs);
    logic [NBR_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {{(NBR_W-1){1'b0}}, nbrs[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/life_row_rule.sv
// Combinational next-state logic for one grid row.
// Ports:
//   row_above, row_cur, row_below : GRID_W-bit rows (already wrapped or zeroed
//                                   vertically by the caller)
//   rule_birth, rule_survive      : 9-bit rule masks indexed by neighbour count
//   row_next                      : GRID_W-bit next generation of row_cur
// Parameter WRAP selects whether the column beyond each edge wraps around
// (torus) or reads as dead.
module life_row_rule
  import life_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter bit WRAP   = 1'b0
) (
  input  logic [GRID_W-1:0] row_above,
  input  logic [GRID_W-1:0] row_cur,
  input  logic [GRID_W-1:0] row_below,
  input  logic [8:0]        rule_birth,
  input  logic [8:0]        rule_survive,
  output logic [GRID_W-1:0] row_next
);

  // Each row is padded by one cell on both sides: bit 0 stands for column -1
  // and bit GRID_W+1 for column GRID_W, so column c's window is bits c..c+2.
  logic [GRID_W+1:0] ext_a;
  logic [GRID_W+1:0] ext_c;
  logic [GRID_W+1:0] ext_b;
  logic [7:0]        nbrs;
  logic [NBR_W-1:0]  n;

  always_comb begin
    ext_a = {(WRAP ? row_above[0] : 1'b0), row_above, (WRAP ? row_above[GRID_W-1] : 1'b0)};
    ext_c = {(WRAP ? row_cur[0]   : 1'b0), row_cur,   (WRAP ? row_cur[GRID_W-1]   : 1'b0)};
    ext_b = {(WRAP ? row_below[0] : 1'b0), row_below, (WRAP ? row_below[GRID_W-1] : 1'b0)};
    nbrs     = '0;
    n        = '0;
    row_next = '0;
    for (int c = 0; c < GRID_W; c++) begin
      nbrs = {ext_a[c], ext_a[c+1], ext_a[c+2],
              ext_c[c],             ext_c[c+2],
              ext_b[c], ext_b[c+1], ext_b[c+2]};
      n = count_nbrs(nbrs);
      row_next[c] = row_cur[c] ? rule_survive[n] : rule_birth[n];
    end
  end

endmodule

// File: rtl/life_grid_engine.sv
// Conway-style cellular automaton engine for a GRID_W x GRID_H grid.
// A step request computes one row per cycle into a shadow buffer from the
// committed map, then commits the whole buffer in a single cycle.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   step_req                 : pulse to compute the next generation (idle only)
//   busy, step_done          : busy from accept to commit; pulse on commit
//   rule_birth, rule_survive : 9-bit rule masks indexed by neighbour count
//   edit_we/op/x/y           : single-cell toggle/set/clear/no-op (idle only)
//   load_we, load_map        : bulk load of the whole map (idle only, clears generation)
//   map_out                  : committed grid, bit y*GRID_W+x
//   generation               : committed generations since reset/load (wraps)
// Build option: define LIFE_TORUS_EN for a toroidal grid; otherwise cells
// beyond the edges are dead.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int GEN_W  = 16,
  parameter int XY_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_req,
  output logic                     busy,
  output logic                     step_done,
  input  logic [8:0]               rule_birth,
  input  logic [8:0]               rule_survive,
  input  logic                     edit_we,
  input  logic [1:0]               edit_op,
  input  logic [XY_W-1:0]          edit_x,
  input  logic [XY_W-1:0]          edit_y,
  input  logic                     load_we,
  input  logic [GRID_W*GRID_H-1:0] load_map,
  output logic [GRID_W*GRID_H-1:0] map_out,
  output logic [GEN_W-1:0]         generation
);

  localparam int N     = GRID_W * GRID_H;
  localparam int ROW_W = $clog2(GRID_H);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);

`ifdef LIFE_TORUS_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  life_state_e       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [N-1:0]      map_q, map_d;
  logic [N-1:0]      shadow_q, shadow_d;
  logic [GEN_W-1:0]  gen_q, gen_d;

  int                row_idx;
  logic [GRID_W-1:0] row_above, row_cur, row_below, row_next;

  logic [31:0]       edit_xw, edit_yw, edit_idx;
  logic              edit_in_range;
  logic [N-1:0]      edit_mask;

  // Neighbour rows for the row under calculation; the vertical edge either
  // wraps to the opposite row or reads as an all-dead row.
  always_comb begin
    row_idx   = int'(row_q);
    row_cur   = map_q[row_idx*GRID_W +: GRID_W];
    row_above = '0;
    row_below = '0;
    if (row_idx == 0) begin
      if (WRAP) row_above = map_q[(GRID_H-1)*GRID_W +: GRID_W];
    end else begin
      row_above = map_q[(row_idx-1)*GRID_W +: GRID_W];
    end
    if (row_idx == GRID_H - 1) begin
      if (WRAP) row_below = map_q[0 +: GRID_W];
    end else begin
      row_below = map_q[(row_idx+1)*GRID_W +: GRID_W];
    end
  end

  life_row_rule #(
    .GRID_W (GRID_W),
    .WRAP   (WRAP)
  ) u_row_rule (
    .row_above    (row_above),
    .row_cur      (row_cur),
    .row_below    (row_below),
    .rule_birth   (rule_birth),
    .rule_survive (rule_survive),
    .row_next     (row_next)
  );

  // Edit coordinates are widened before the range check so that a grid of
  // 64 columns still compares correctly against a 6-bit coordinate.
  always_comb begin
    edit_xw       = {{(32-XY_W){1'b0}}, edit_x};
    edit_yw       = {{(32-XY_W){1'b0}}, edit_y};
    edit_in_range = (edit_xw < 32'(GRID_W)) && (edit_yw < 32'(GRID_H));
    edit_idx      = edit_yw * 32'(GRID_W) + edit_xw;
    edit_mask     = {{(N-1){1'b0}}, 1'b1} << edit_idx;
  end

  // Next-state logic. Host writes are only honoured when idle, with
  // load > edit > step priority; CALC never touches map_q, so the committed
  // map stays a stable source for the whole step.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    map_d    = map_q;
    shadow_d = shadow_q;
    gen_d    = gen_q;
    unique case (state_q)
      IDLE: begin
        if (load_we) begin
          map_d = load_map;
          gen_d = '0;
        end else if (edit_we) begin
          if (edit_in_range) begin
            unique case (edit_op)
              EDIT_TOGGLE: map_d = map_q ^ edit_mask;
              EDIT_SET:    map_d = map_q | edit_mask;
              EDIT_CLEAR:  map_d = map_q & ~edit_mask;
              EDIT_NOP:    map_d = map_q;
              default:     map_d = map_q;
            endcase
          end
        end else if (step_req) begin
          state_d = CALC;
          row_d   = '0;
        end
      end
      CALC: begin
        shadow_d[row_idx*GRID_W +: GRID_W] = row_next;
        if (row_q == LAST_ROW) begin
          state_d = COMMIT;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      COMMIT: begin
        map_d   = shadow_q;
        gen_d   = gen_q + GEN_W'(1);
        row_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      map_q    <= '0;
      shadow_q <= '0;
      gen_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      map_q    <= map_d;
      shadow_q <= shadow_d;
      gen_q    <= gen_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign step_done  = (state_q == COMMIT);
  assign map_out    = map_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed self-checking bench for life_grid_engine on the default 16x16 grid.
// Inputs are driven and outputs sampled on the falling clock edge.
// The glider test only applies when LIFE_TORUS_EN is defined; the edge
// blinker expectation depends on the same option.
module tb_life_grid_engine;

  logic         clk;
  logic         rst;
  logic         stepReq;
  logic         busy;
  logic         stepDone;
  logic [8:0]   ruleBirth;
  logic [8:0]   ruleSurvive;
  logic         editWe;
  logic [1:0]   editOp;
  logic [5:0]   editX;
  logic [5:0]   editY;
  logic         loadWe;
  logic [255:0] loadMap;
  logic [255:0] mapOut;
  logic [15:0]  generation;

  int checkCount = 0;
  int passCount  = 0;

  life_grid_engine dut (
    .clk          (clk),
    .rst          (rst),
    .step_req     (stepReq),
    .busy         (busy),
    .step_done    (stepDone),
    .rule_birth   (ruleBirth),
    .rule_survive (ruleSurvive),
    .edit_we      (editWe),
    .edit_op      (editOp),
    .edit_x       (editX),
    .edit_y       (editY),
    .load_we      (loadWe),
    .load_map     (loadMap),
    .map_out      (mapOut),
    .generation   (generation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] cellBit(input int x, input int y);
    logic [255:0] v;
    v = '0;
    v[y*16 + x] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Drive one cycle of strobes from a falling edge, then return them to idle.
  task automatic applyStimulus(input logic ld, input logic [255:0] pat,
                               input logic ed, input logic [1:0] op,
                               input int x, input int y, input logic st);
    loadWe  = ld;
    loadMap = pat;
    editWe  = ed;
    editOp  = op;
    editX   = 6'(x);
    editY   = 6'(y);
    stepReq = st;
    @(negedge clk);
    loadWe  = 1'b0;
    editWe  = 1'b0;
    stepReq = 1'b0;
  endtask

  // Issue a step and return the cycle offset at which step_done appeared
  // (-1 if never within the budget); returns with the commit visible.
  task automatic runStep(output int lat);
    lat = -1;
    stepReq = 1'b1;
    @(negedge clk);
    stepReq = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (stepDone) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  logic [255:0] blinkH, blinkV, edgeBlink, edgeExp, bars, glider, gliderMoved;
  int           lat;
  logic         seenDone;

  initial begin
    rst         = 1'b1;
    stepReq     = 1'b0;
    ruleBirth   = 9'h008;
    ruleSurvive = 9'h00C;
    editWe      = 1'b0;
    editOp      = 2'b11;
    editX       = '0;
    editY       = '0;
    loadWe      = 1'b0;
    loadMap     = '0;

    blinkH    = cellBit(4,5) | cellBit(5,5) | cellBit(6,5);
    blinkV    = cellBit(5,4) | cellBit(5,5) | cellBit(5,6);
    edgeBlink = cellBit(15,0) | cellBit(0,0) | cellBit(1,0);
`ifdef LIFE_TORUS_EN
    edgeExp   = cellBit(0,15) | cellBit(0,0) | cellBit(0,1);
`else
    edgeExp   = '0;
`endif
    bars        = cellBit(4,4) | cellBit(5,4) | cellBit(6,4)
                | cellBit(4,6) | cellBit(5,6) | cellBit(6,6);
    glider      = cellBit(1,0) | cellBit(2,1) | cellBit(0,2) | cellBit(1,2) | cellBit(2,2);
    gliderMoved = cellBit(2,1) | cellBit(3,2) | cellBit(1,3) | cellBit(2,3) | cellBit(3,3);

    repeat (3) @(negedge clk);
    checkOutput("reset_map", mapOut, '0);
    checkOutput("reset_gen", 256'(generation), '0);
    checkOutput("reset_busy", 256'(busy), '0);
    checkOutput("reset_done", 256'(stepDone), '0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] blinker");
    applyStimulus(1'b1, blinkH, 1'b0, 2'b11, 0, 0, 1'b0);
    checkOutput("load_map", mapOut, blinkH);
    checkOutput("load_gen", 256'(generation), '0);
    runStep(lat);
    checkOutput("step_latency", 256'(lat), 256'(17));
    checkOutput("blinker_v", mapOut, blinkV);
    checkOutput("blinker_gen1", 256'(generation), 256'(1));
    checkOutput("idle_after_commit", 256'(busy), '0);
    runStep(lat);
    checkOutput("blinker_h", mapOut, blinkH);
    checkOutput("blinker_gen2", 256'(generation), 256'(2));

    $display("[TB] writes while busy");
    stepReq = 1'b1;
    @(negedge clk);
    stepReq = 1'b0;
    checkOutput("busy_after_accept", 256'(busy), 256'(1));
    applyStimulus(1'b1, '1, 1'b1, 2'b01, 1, 1, 1'b1);
    checkOutput("busy_load_ignored", mapOut, blinkH);
    seenDone = 1'b0;
    for (int k = 0; k < 40 && !seenDone; k++) begin
      seenDone = stepDone;
      @(negedge clk);
    end
    checkOutput("busy_step_done_seen", 256'(seenDone), 256'(1));
    checkOutput("busy_result", mapOut, blinkV);
    checkOutput("busy_gen", 256'(generation), 256'(3));
    repeat (20) @(negedge clk);
    checkOutput("step_not_queued", 256'(generation), 256'(3));

    $display("[TB] priority");
    applyStimulus(1'b1, blinkH, 1'b1, 2'b01, 0, 0, 1'b1);
    checkOutput("prio_map", mapOut, blinkH);
    checkOutput("prio_gen_cleared", 256'(generation), '0);
    checkOutput("prio_step_dropped", 256'(busy), '0);

    $display("[TB] edits");
    applyStimulus(1'b1, '0, 1'b0, 2'b11, 0, 0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 2'b00, 3, 2, 1'b0);
    checkOutput("toggle_on", mapOut, cellBit(3,2));
    applyStimulus(1'b0, '0, 1'b1, 2'b00, 3, 2, 1'b0);
    checkOutput("toggle_off", mapOut, '0);
    applyStimulus(1'b0, '0, 1'b1, 2'b01, 16, 0, 1'b0);
    checkOutput("set_x_oob", mapOut, '0);
    applyStimulus(1'b0, '0, 1'b1, 2'b01, 0, 16, 1'b0);
    checkOutput("set_y_oob", mapOut, '0);
    applyStimulus(1'b0, '0, 1'b1, 2'b01, 15, 15, 1'b0);
    checkOutput("set_corner", mapOut, cellBit(15,15));
    applyStimulus(1'b0, '0, 1'b1, 2'b10, 15, 15, 1'b0);
    checkOutput("clear_corner", mapOut, '0);
    applyStimulus(1'b0, '0, 1'b1, 2'b01, 3, 2, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 2'b11, 3, 2, 1'b0);
    checkOutput("nop_keeps", mapOut, cellBit(3,2));
    checkOutput("edit_gen", 256'(generation), '0);

    $display("[TB] edge blinker");
    applyStimulus(1'b1, edgeBlink, 1'b0, 2'b11, 0, 0, 1'b0);
    runStep(lat);
    checkOutput("edge_result", mapOut, edgeExp);

    $display("[TB] rules");
    applyStimulus(1'b1, bars, 1'b0, 2'b11, 0, 0, 1'b0);
    ruleBirth = 9'h048;
    runStep(lat);
    checkOutput("b36_born", 256'(mapOut[5*16+5]), 256'(1));
    checkOutput("b36_survive", 256'(mapOut[4*16+5]), 256'(1));
    applyStimulus(1'b1, bars, 1'b0, 2'b11, 0, 0, 1'b0);
    ruleBirth = 9'h008;
    runStep(lat);
    checkOutput("b3_dead", 256'(mapOut[5*16+5]), '0);
    checkOutput("b3_survive", 256'(mapOut[4*16+5]), 256'(1));

`ifdef LIFE_TORUS_EN
    $display("[TB] glider");
    applyStimulus(1'b1, glider, 1'b0, 2'b11, 0, 0, 1'b0);
    repeat (4) runStep(lat);
    checkOutput("glider_4", mapOut, gliderMoved);
    repeat (60) runStep(lat);
    checkOutput("glider_64", mapOut, glider);
    checkOutput("glider_gen", 256'(generation), 256'(64));
`endif

    $display("[TB] reset during calc");
    applyStimulus(1'b1, blinkH, 1'b0, 2'b11, 0, 0, 1'b0);
    runStep(lat);
    checkOutput("pre_reset_gen", 256'(generation), 256'(1));
    stepReq = 1'b1;
    @(negedge clk);
    stepReq = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_map", mapOut, '0);
    checkOutput("rst_gen", 256'(generation), '0);
    checkOutput("rst_busy", 256'(busy), '0);
    rst = 1'b0;
    seenDone = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (stepDone) seenDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("rst_no_done", 256'(seenDone), '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
